// File: rtl/reg_dump_streamer_if.sv
// Byte-stream and register-file debug port bundle for reg_dump_streamer.
// master: the streamer (drives dbg_sel and the byte stream).
// slave : the environment (register file, transmitter, host start).
interface reg_dump_streamer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             done;
  logic [4:0]       dbg_sel;
  logic [WIDTH-1:0] dbg_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  start,
    output busy,
    output done,
    output dbg_sel,
    input  dbg_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  dbg_sel,
    output dbg_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// Register dump streamer: on start, walks the debug select over registers
// 0..NUM_REGS-1, snapshots each value and sends it MSB byte first on a
// valid/ready byte stream. All outputs are registered.
// Optional feature macro: REG_DUMP_HEADER_EN -- prefixes every register with
// a header byte {3'b000, index} and appends a trailer byte 8'hFF after the
// last register.
module reg_dump_streamer #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input logic                clk,
  input logic                reset,
  reg_dump_streamer_if.master bus
);

  localparam int BYTES = WIDTH / 8;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  // byte_cnt value of the last byte of one register (header included)
  localparam int LAST_CNT = BYTES - 1 + HDR_BYTES;
  localparam int CNT_W    = (LAST_CNT < 1) ? 1 : $clog2(LAST_CNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT_V = CNT_W'(LAST_CNT);
  localparam logic [4:0]       LAST_REG   = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Data byte idx of a register value, byte 0 being the most significant.
  function automatic logic [7:0] f_data_byte(input logic [WIDTH-1:0] data,
                                             input logic [CNT_W-1:0] idx);
    logic [WIDTH-1:0] w_shifted;
    w_shifted = data << {idx, 3'b000};
    return w_shifted[WIDTH-1 -: 8];
  endfunction

  state_e           r_state,    w_state_nxt;
  logic [4:0]       r_reg_idx,  w_reg_idx_nxt;
  logic [4:0]       r_dbg_sel;
  logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [WIDTH-1:0] r_shadow,   w_shadow_nxt;
  logic [7:0]       r_tx_data,  w_tx_data_nxt;
  logic             r_tx_valid, w_tx_valid_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_done,     w_done_nxt;

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.dbg_sel  = r_dbg_sel;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;

  // State register plus registered outputs; reset returns to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_reg_idx  <= 5'd0;
      r_dbg_sel  <= 5'd0;
      r_byte_cnt <= '0;
      r_shadow   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_reg_idx  <= w_reg_idx_nxt;
      // dbg_sel follows reg_idx on the same edge so LOAD sees a settled select
      r_dbg_sel  <= w_reg_idx_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    w_state_nxt    = r_state;
    w_reg_idx_nxt  = r_reg_idx;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shadow_nxt   = r_shadow;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = ST_LOAD;
          w_reg_idx_nxt = 5'd0;
          w_busy_nxt    = 1'b1;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // snapshot once; later writes to this register are not reflected
        w_shadow_nxt   = bus.dbg_data;
        w_byte_cnt_nxt = '0;
        w_tx_valid_nxt = 1'b1;
`ifdef REG_DUMP_HEADER_EN
        w_tx_data_nxt  = {3'b000, r_reg_idx};
`else
        w_tx_data_nxt  = f_data_byte(bus.dbg_data, '0);
`endif
        w_state_nxt    = ST_SEND;
      end

      ST_SEND: begin
        if (bus.tx_ready) begin
          if (r_byte_cnt == LAST_CNT_V) begin
            if (r_reg_idx == LAST_REG) begin
`ifdef REG_DUMP_HEADER_EN
              w_state_nxt    = ST_TRAIL;
              w_tx_data_nxt  = 8'hFF;
              w_tx_valid_nxt = 1'b1;
`else
              w_state_nxt    = ST_DONE;
              w_tx_valid_nxt = 1'b0;
              w_busy_nxt     = 1'b0;
              w_done_nxt     = 1'b1;
`endif
            end else begin
              w_state_nxt    = ST_LOAD;
              w_reg_idx_nxt  = r_reg_idx + 5'd1;
              w_tx_valid_nxt = 1'b0;
            end
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
`ifdef REG_DUMP_HEADER_EN
            // byte_cnt 0 is the header, so data byte index lags by one
            w_tx_data_nxt  = f_data_byte(r_shadow, r_byte_cnt);
`else
            w_tx_data_nxt  = f_data_byte(r_shadow, r_byte_cnt + CNT_W'(1));
`endif
          end
        end else begin
          // stalled: byte and valid held
          w_state_nxt = ST_SEND;
        end
      end

`ifdef REG_DUMP_HEADER_EN
      ST_TRAIL: begin
        if (bus.tx_ready) begin
          w_state_nxt    = ST_DONE;
          w_tx_valid_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
        end else begin
          w_state_nxt = ST_TRAIL;
        end
      end
`endif

      ST_DONE: begin
        // start is ignored here; done drops on the way back to idle
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: random register contents and
// tx_ready patterns, compared with a byte stream built directly from the
// register array contents at dump start.
module tb_reg_dump_streamer;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int BYTES    = WIDTH / 8;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
  localparam int TRL = 1;
`else
  localparam int HDR = 0;
  localparam int TRL = 0;
`endif
  localparam int PER     = BYTES + HDR;
  localparam int LATENCY = NUM_REGS * (1 + PER) + TRL + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_dump_streamer_if #(.WIDTH(WIDTH)) bus ();

  reg_dump_streamer #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [WIDTH-1:0] regs [NUM_REGS];
  assign bus.dbg_data = regs[bus.dbg_sel];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] cap [$];
  int done_cnt = 0;
  int done_edge = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor at negedge: record handshakes, done pulses and stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall.valid", 64'(bus.tx_valid), 64'd1);
          check_eq("stall.data", 64'(bus.tx_data), 64'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          cap.push_back(bus.tx_data);
          if (ready_mode == 1 && (cap.size() % 2) == 1) stall_cnt = 3;
        end
        if (bus.done) begin
          done_cnt++;
          done_edge = cyc + 1;
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
      end
    end
  end

  // tx_ready driver: 0 = always ready, 1 = 3-cycle stall on every 2nd byte, else random.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.tx_ready = 1'b1;
        1: begin
          if (stall_cnt > 0) begin
            bus.tx_ready = 1'b0;
            stall_cnt--;
          end else begin
            bus.tx_ready = 1'b1;
          end
        end
        default: bus.tx_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic run_dump(input string name, input int mode, input bit extra_start,
                          input bit wr3, input bit rst_mid);
    logic [7:0] expq [$];
    int n_edge;
    int rel;
    bit wrote;
    bit aborted;
    expq = {};
    for (int r = 0; r < NUM_REGS; r++) begin
      if (HDR != 0) expq.push_back(8'(r));
      for (int b = 0; b < BYTES; b++) expq.push_back(regs[r][WIDTH-1-8*b -: 8]);
    end
    if (TRL != 0) expq.push_back(8'hFF);
    cap.delete();
    done_cnt   = 0;
    stall_cnt  = 0;
    ready_mode = mode;
    wrote      = 1'b0;
    aborted    = 1'b0;

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    n_edge = cyc + 1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq({name, ".busy_on"}, 64'(bus.busy), 64'd1);

    rel = 0;
    while (done_cnt == 0 && !aborted && rel < 5000) begin
      @(posedge clk);
      #1;
      rel++;
      if (extra_start) bus.start = (cyc == n_edge + 49);
      if (wr3 && !wrote && cap.size() >= 3 * PER + 1) begin
        regs[3] = 32'h1234_5678;
        wrote = 1'b1;
      end
      if (rst_mid && cap.size() >= 10 * PER + 1) begin
        reset = 1'b1;
        #1;
        check_eq({name, ".rst_valid"}, 64'(bus.tx_valid), 64'd0);
        check_eq({name, ".rst_busy"}, 64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        aborted = 1'b1;
      end
    end
    bus.start = 1'b0;

    if (aborted) begin
      repeat (3) @(negedge clk);
      check_eq({name, ".idle_valid"}, 64'(bus.tx_valid), 64'd0);
      check_eq({name, ".idle_sel"}, 64'(bus.dbg_sel), 64'd0);
      check_eq({name, ".idle_busy"}, 64'(bus.busy), 64'd0);
    end else begin
      check_eq({name, ".done_seen"}, 64'(done_cnt), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      check_eq({name, ".done_once"}, 64'(done_cnt), 64'd1);
      check_eq({name, ".busy_off"}, 64'(bus.busy), 64'd0);
      check_eq({name, ".len"}, 64'(cap.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < cap.size(); i++)
        check_eq($sformatf("%s.byte%0d", name, i), 64'(cap[i]), 64'(expq[i]));
      if (mode == 0)
        check_eq({name, ".done_time"}, 64'(done_edge - n_edge), 64'(LATENCY));
    end
    ready_mode = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    regs[0] = '0;
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = WIDTH'(i);
    regs[5] = 32'hDEAD_BEEF;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.busy", 64'(bus.busy), 64'd0);
    check_eq("rst.done", 64'(bus.done), 64'd0);
    check_eq("rst.sel", 64'(bus.dbg_sel), 64'd0);
    check_eq("rst.valid", 64'(bus.tx_valid), 64'd0);
    check_eq("rst.data", 64'(bus.tx_data), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle.valid", 64'(bus.tx_valid), 64'd0);
    check_eq("idle.busy", 64'(bus.busy), 64'd0);

    // index pattern with x5 = DEADBEEF, free-flowing then back-pressured
    run_dump("t1", 0, 1'b0, 1'b0, 1'b0);
    check_eq("t1.x5_b0", 64'(cap[5 * PER + HDR]), 64'hDE);
    check_eq("t1.x5_b3", 64'(cap[5 * PER + HDR + 3]), 64'hEF);
    run_dump("t2_bp", 1, 1'b0, 1'b0, 1'b0);

    // second start mid-dump is ignored
    fill_random();
    run_dump("t3_restart", 0, 1'b1, 1'b0, 1'b0);

    // reset in the middle of x10, then a clean dump from x0
    fill_random();
    run_dump("t4_rst", 0, 1'b0, 1'b0, 1'b1);
    run_dump("t4_after", 2, 1'b0, 1'b0, 1'b0);

    // x3 rewritten during its own SEND: old value now, new value next time
    fill_random();
    run_dump("t5_wr3", 0, 1'b0, 1'b1, 1'b0);
    run_dump("t5_next", 2, 1'b0, 1'b0, 1'b0);
    check_eq("t5.x3_new", 64'(cap[3 * PER + HDR]), 64'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
